// File: rtl/wb_scheduler.sv
// ---------------------------------------------------------------------------
// wb_scheduler
//   Writeback arbiter and register scoreboard for a three-unit pipeline.
//   Three execution units (ALU, LSU, MDU) compete for one register-file
//   write port through a round-robin arbiter. The winning request is written
//   one cycle after its grant. A 32-entry pending scoreboard tracks registers
//   that have an issued but not yet written result. It is used to stall WAW
//   issues and to answer RAW hazard queries.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid[2:0]        writeback requests: bit0 ALU, bit1 LSU, bit2 MDU
//   req_ready[2:0]        one-hot grant, combinational
//   req_rd[14:0]          destination of source i in bits [5i+4:5i]
//   req_data[3*XLEN-1:0]  data of source i in bits [XLEN*i +: XLEN]
//   wb_we/wb_rd/wb_data   registered register-file write port
//   iss_valid/iss_rd      issue-side reservation request
//   iss_ready             0 while iss_rd is already pending (WAW stall)
//   rs1/rs2               hazard query addresses
//   rs1_busy/rs2_busy     pending bit of rs1/rs2, combinational
//   pending[31:0]         scoreboard, bit 0 always 0
// ---------------------------------------------------------------------------
module wb_scheduler #(
  parameter int XLEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          req_valid,
  output logic [2:0]          req_ready,
  input  logic [14:0]         req_rd,
  input  logic [3*XLEN-1:0]   req_data,
  output logic                wb_we,
  output logic [4:0]          wb_rd,
  output logic [XLEN-1:0]     wb_data,
  input  logic                iss_valid,
  input  logic [4:0]          iss_rd,
  output logic                iss_ready,
  input  logic [4:0]          rs1,
  input  logic [4:0]          rs2,
  output logic                rs1_busy,
  output logic                rs2_busy,
  output logic [31:0]         pending
);

  // Source fields unpacked into per-source arrays
  logic [4:0]      src_rd   [3];
  logic [XLEN-1:0] src_data [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_src
      assign src_rd[gi]   = req_rd[5*gi +: 5];
      assign src_data[gi] = req_data[XLEN*gi +: XLEN];
    end
  endgenerate

  // State
  logic [1:0]      rr_ptr_reg;
  logic            wb_we_reg;
  logic [4:0]      wb_rd_reg;
  logic [XLEN-1:0] wb_data_reg;
  logic [31:0]     pending_reg;

  // Arbiter scratch
  logic [1:0]      scan_idx;
  logic [1:0]      grant_idx;
  logic            grant_any;

  function automatic logic [1:0] wrap_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Round-robin search starting at rr_ptr_reg, ascending with wrap 2 -> 0.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 2'd0;
    scan_idx  = rr_ptr_reg;
    for (int k = 0; k < 3; k++) begin
      if (!grant_any && req_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
      scan_idx = wrap_inc(scan_idx);
    end
  end

  // Grants are held off while reset is asserted.
  assign req_ready = (grant_any && rst_n) ? (3'b001 << grant_idx) : 3'b000;

  // Issue side: stall only when the destination already has a result in flight.
  logic iss_fire;
  assign iss_ready = !((iss_rd != 5'd0) && pending_reg[iss_rd]);
  assign iss_fire  = iss_valid && iss_ready;

  // Scoreboard update. The set is applied after the clear so a reservation
  // wins over a same-edge writeback to the same register.
  logic [31:0] set_vec;
  logic [31:0] clr_vec;
  logic [31:0] pending_next;

  assign set_vec      = iss_fire  ? (32'h1 << iss_rd)    : 32'h0;
  assign clr_vec      = wb_we_reg ? (32'h1 << wb_rd_reg) : 32'h0;
  assign pending_next = ((pending_reg & ~clr_vec) | set_vec) & ~32'h1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg  <= 2'd0;
      wb_we_reg   <= 1'b0;
      wb_rd_reg   <= 5'd0;
      wb_data_reg <= '0;
      pending_reg <= 32'h0;
    end else begin
      pending_reg <= pending_next;
      if (grant_any) begin
        // A grant with rd=0 is consumed and rotates the pointer but never writes.
        rr_ptr_reg  <= wrap_inc(grant_idx);
        wb_we_reg   <= (src_rd[grant_idx] != 5'd0);
        wb_rd_reg   <= src_rd[grant_idx];
        wb_data_reg <= src_data[grant_idx];
      end else begin
        wb_we_reg   <= 1'b0;
      end
    end
  end

  assign wb_we    = wb_we_reg;
  assign wb_rd    = wb_rd_reg;
  assign wb_data  = wb_data_reg;
  assign pending  = pending_reg;

  // No bypass: a busy bit drops only once the scoreboard itself has cleared.
  assign rs1_busy = (rs1 != 5'd0) && pending_reg[rs1];
  assign rs2_busy = (rs2 != 5'd0) && pending_reg[rs2];

endmodule

// File: tb/tb_wb_scheduler.sv
// ---------------------------------------------------------------------------
// tb_wb_scheduler
//   Self-checking bench for wb_scheduler. A behavioural model (pointer as an
//   integer, scoreboard as a bit array, expected write port as plain values)
//   predicts every output each cycle. Directed scenarios come first, followed
//   by randomized traffic with occasional resets.
// ---------------------------------------------------------------------------
module tb_wb_scheduler;

  localparam int XLEN = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [2:0]        req_valid;
  logic [2:0]        req_ready;
  logic [14:0]       req_rd;
  logic [3*XLEN-1:0] req_data;
  logic              wb_we;
  logic [4:0]        wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              iss_valid;
  logic [4:0]        iss_rd;
  logic              iss_ready;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic              rs1_busy;
  logic              rs2_busy;
  logic [31:0]       pending;

  wb_scheduler #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .rs1       (rs1),
    .rs2       (rs2),
    .rs1_busy  (rs1_busy),
    .rs2_busy  (rs2_busy),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model
  int               m_rr;
  logic             m_we;
  logic [4:0]       m_rd;
  logic [XLEN-1:0]  m_data;
  logic             m_hold;   // wb_rd/wb_data hold a value the bench knows
  logic [31:0]      m_pend;

  task automatic model_reset();
    m_rr   = 0;
    m_we   = 1'b0;
    m_rd   = 5'd0;
    m_data = '0;
    m_hold = 1'b1;
    m_pend = 32'h0;
  endtask

  // One clock cycle: drive inputs, check every output against the model,
  // advance the model, then let the edge happen.
  task automatic cycle(input logic [2:0] v, input logic [14:0] rd,
                       input logic [3*XLEN-1:0] data, input logic iv,
                       input logic [4:0] ird, input logic [4:0] r1,
                       input logic [4:0] r2);
    int          g;
    logic [2:0]  exp_ready;
    logic        exp_iss;
    logic [31:0] nxt;
    @(negedge clk);
    req_valid = v; req_rd = rd; req_data = data;
    iss_valid = iv; iss_rd = ird; rs1 = r1; rs2 = r2;
    #1;
    g = -1;
    for (int k = 0; k < 3; k++) begin
      int idx;
      idx = (m_rr + k) % 3;
      if (g < 0 && v[idx]) g = idx;
    end
    exp_ready = (g >= 0) ? (3'b001 << g) : 3'b000;
    exp_iss   = !(ird != 0 && m_pend[ird]);
    $display("cyc t=%0t valid=%b ready=%b iss=%b/%0d we=%b rd=%0d data=%h pend=%h",
             $time, v, req_ready, iv, ird, wb_we, wb_rd, wb_data, pending);
    check("req_ready", req_ready, exp_ready);
    check("iss_ready", iss_ready, exp_iss);
    check("rs1_busy", rs1_busy, (r1 != 0) && m_pend[r1]);
    check("rs2_busy", rs2_busy, (r2 != 0) && m_pend[r2]);
    check("pending", pending, m_pend);
    check("wb_we", wb_we, m_we);
    if (m_we || m_hold) begin
      check("wb_rd", wb_rd, m_rd);
      check("wb_data", wb_data, m_data);
    end
    // Next state
    nxt = m_pend;
    if (m_we) nxt[m_rd] = 1'b0;
    if (iv && exp_iss && ird != 0) nxt[ird] = 1'b1;
    m_pend = nxt;
    if (g >= 0) begin
      m_rd   = rd[5*g +: 5];
      m_data = data[XLEN*g +: XLEN];
      m_we   = (m_rd != 0);
      m_hold = m_we;
      m_rr   = (g + 1) % 3;
    end else begin
      m_we = 1'b0;
    end
    @(posedge clk);
  endtask

  // Reset pulse starting at the falling edge after the last cycle.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 3'b111; iss_valid = 1'b1; iss_rd = 5'd3;
    #1;
    $display("rst t=%0t ready=%b iss_ready=%b we=%b pend=%h", $time, req_ready, iss_ready, wb_we, pending);
    check("rst_req_ready", req_ready, 3'b000);
    check("rst_iss_ready", iss_ready, 1'b1);
    check("rst_wb_we", wb_we, 1'b0);
    check("rst_wb_rd", wb_rd, 5'd0);
    check("rst_wb_data", wb_data, '0);
    check("rst_pending", pending, 32'h0);
    @(posedge clk);
    #1;
    check("rst_wb_we_hold", wb_we, 1'b0);
    check("rst_pending_hold", pending, 32'h0);
    #1;
    rst_n = 1'b1;
    req_valid = 3'b000; iss_valid = 1'b0;
    model_reset();
  endtask

  localparam logic [14:0] RD123 = {5'd3, 5'd2, 5'd1};

  initial begin
    rst_n = 1'b0;
    req_valid = 3'b000; req_rd = '0; req_data = '0;
    iss_valid = 1'b0; iss_rd = '0; rs1 = '0; rs2 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // All three sources valid: ALU, LSU, MDU, ALU with wb_rd 1,2,3,1
    cycle(3'b111, RD123, {32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 0, 0, 0, 0);
    #1 check("rr_wb_rd_0", wb_rd, 5'd1);
    cycle(3'b111, RD123, {32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 0, 0, 0, 0);
    #1 check("rr_wb_rd_1", wb_rd, 5'd2);
    cycle(3'b111, RD123, {32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 0, 0, 0, 0);
    #1 check("rr_wb_rd_2", wb_rd, 5'd3);
    cycle(3'b111, RD123, {32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, 0, 0, 0, 0);
    #1 check("rr_wb_rd_3", wb_rd, 5'd1);
    cycle(3'b000, '0, '0, 0, 0, 0, 0);
    #1 check("idle_we", wb_we, 1'b0);

    // Issue rd=5, LSU writes it back three cycles later, second issue stalls
    cycle(3'b000, '0, '0, 1, 5'd5, 5'd5, 5'd0);
    #1 check("iss5_pending", pending[5], 1'b1);
    cycle(3'b000, '0, '0, 0, 0, 5'd5, 5'd0);
    cycle(3'b000, '0, '0, 1, 5'd5, 5'd5, 5'd0);
    cycle(3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEAD_BEEF, 32'h0}, 1, 5'd5, 5'd5, 5'd0);
    #1 check("lsu_we", wb_we, 1'b1);
    check("lsu_data", wb_data, 32'hDEAD_BEEF);
    cycle(3'b000, '0, '0, 1, 5'd5, 5'd5, 5'd0);
    cycle(3'b000, '0, '0, 1, 5'd5, 5'd5, 5'd0);
    #1 check("reissue5_pending", pending[5], 1'b1);

    // Writeback to non-pending rd=7 coincident with a new reservation of 7
    cycle(3'b001, {5'd0, 5'd0, 5'd7}, {32'h0, 32'h0, 32'h7777_0007}, 0, 0, 5'd7, 5'd0);
    cycle(3'b000, '0, '0, 1, 5'd7, 5'd7, 5'd0);
    #1 check("set_wins_7", pending[7], 1'b1);

    // MDU rd=0 grant: consumed, no write, pointer returns to ALU
    cycle(3'b010, {5'd0, 5'd9, 5'd0}, {32'h0, 32'h9999_9999, 32'h0}, 0, 0, 0, 0);
    cycle(3'b100, {5'd0, 5'd0, 5'd0}, {32'hFFFF_FFFF, 32'h0, 32'h0}, 0, 0, 0, 0);
    #1 check("rd0_no_we", wb_we, 1'b0);
    cycle(3'b111, RD123, '0, 0, 0, 0, 0);

    // Reset right after a grant: pulse suppressed, next grant to ALU
    cycle(3'b010, {5'd0, 5'd9, 5'd0}, {32'h0, 32'h1234_5678, 32'h0}, 1, 5'd9, 0, 0);
    do_reset();
    cycle(3'b111, RD123, '0, 0, 0, 0, 0);
    #1 check("post_rst_alu", wb_rd, 5'd1);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      logic [14:0] rr;
      for (int s = 0; s < 3; s++)
        rr[5*s +: 5] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 9));
      if ($urandom_range(0, 63) == 0)
        do_reset();
      else
        cycle(3'($urandom), rr, {$urandom, $urandom, $urandom},
              1'($urandom), 5'($urandom_range(0, 9)),
              5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_scheduler.md
WB_SCHEDULER -- requirements
Module: wb_scheduler

Interface
REQ-001 Parameter XLEN SHALL default to 32 and SHALL set the width of every data path.
REQ-002 Port clk SHALL be an input of 1 bit and SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n SHALL be an input of 1 bit and SHALL be the reset, asynchronous and active-low.
REQ-004 Port req_valid SHALL be an input of 3 bits carrying one writeback request per source: bit0 ALU, bit1 LSU, bit2 MDU.
REQ-005 Port req_ready SHALL be an output of 3 bits carrying one grant per source.
REQ-006 Port req_rd SHALL be an input of 15 bits holding the destination of source i in bits [5i+4:5i].
REQ-007 Port req_data SHALL be an input of 3*XLEN bits holding the data of source i in bits [XLEN*i+XLEN-1:XLEN*i].
REQ-008 Ports wb_we (output, 1 bit), wb_rd (output, 5 bits) and wb_data (output, XLEN bits) SHALL drive the register-file write port.
REQ-009 Ports iss_valid (input, 1 bit), iss_rd (input, 5 bits) and iss_ready (output, 1 bit) SHALL form the issue-side reservation handshake.
REQ-010 Ports rs1 and rs2 SHALL be inputs of 5 bits each, and rs1_busy and rs2_busy SHALL be outputs of 1 bit each, forming the hazard query.
REQ-011 Port pending SHALL be an output of 32 bits exposing the scoreboard, one bit per register.

Function
REQ-012 A transfer from source i SHALL occur in any cycle where req_valid[i]=1 and req_ready[i]=1.
REQ-013 At most one req_ready bit SHALL be high per cycle.
- req_ready SHALL be combinational from req_valid and the round-robin pointer.
- req_ready[i] SHALL never be high while req_valid[i]=0.
REQ-014 Arbitration SHALL be round-robin.
- Search SHALL start at pointer rr_ptr (0..2) and proceed in ascending order, wrapping 2 to 0.
- After a grant to source g, rr_ptr SHALL become (g+1) mod 3.
- With no grant, rr_ptr SHALL hold.
REQ-015 A granted transfer in cycle N SHALL appear on wb_we/wb_rd/wb_data, all registered, in cycle N+1 for exactly one cycle; latency SHALL be 1 and throughput SHALL be one write per cycle.
REQ-016 A granted request with rd=0 SHALL be consumed and SHALL rotate rr_ptr, but wb_we SHALL stay 0 in N+1.
REQ-017 When no transfer occurs, wb_we SHALL be 0 in the next cycle; wb_rd and wb_data SHALL hold their previous values.
REQ-018 An issue reservation SHALL occur when iss_valid=1 and iss_ready=1.
- iss_ready SHALL be 0 when iss_rd!=0 and pending[iss_rd]=1 (WAW stall); otherwise it SHALL be 1.
- A reservation with iss_rd!=0 SHALL set pending[iss_rd] at the next edge.
- A reservation with iss_rd=0 SHALL change nothing.
REQ-019 pending[wb_rd] SHALL clear at the clock edge that ends a cycle with wb_we=1, coincident with the register-file write.
REQ-020 If a set and a clear target the same register at one edge, the set SHALL win.
REQ-021 rs1_busy SHALL equal pending[rs1], and rs2_busy SHALL equal pending[rs2], combinationally.
- Each SHALL be forced to 0 for address 0.
- A busy bit SHALL fall in the cycle after the wb_we pulse; no bypass SHALL be provided.
REQ-022 pending[0] SHALL be constant 0.
REQ-023 A writeback to a register whose pending bit is 0 SHALL still be written and SHALL leave pending unchanged.

Reset
REQ-024 While rst_n=0, the block SHALL drive wb_we=0, wb_rd=0, wb_data=0, pending=0, rr_ptr=0 and req_ready=0, and iss_ready SHALL be 1.
REQ-025 Assertion of rst_n=0 in the cycle after a grant SHALL suppress the pending wb_we pulse, and the granted data SHALL be lost.
REQ-026 After rst_n rises, the first edge SHALL resume normal operation with rr_ptr=0.

Verification
REQ-027 All three sources valid every cycle, rd=1/2/3 -> grants ALU, LSU, MDU, ALU...; wb_rd sequence 1,2,3,1 starting one cycle after the first grant.
REQ-028 Issue rd=5 in cycle 0 -> pending[5]=1 and rs1=5 busy from cycle 1; LSU writes rd=5, data=0xDEADBEEF, granted in cycle 3 -> wb_we=1 in cycle 4 and rs1_busy=0 in cycle 5.
REQ-029 Second issue of rd=5 while pending -> iss_ready=0 until the cycle after the rd=5 wb_we pulse, then 1.
REQ-030 Issue of rd=7 in the same cycle that wb_we=1 with wb_rd=7 -> pending[7]=1 afterwards.
REQ-031 MDU request with rd=0, data=0xFFFFFFFF -> req_ready[2]=1, wb_we stays 0, rr_ptr becomes 0.
REQ-032 rst_n pulled low for 1 cycle immediately after a grant -> no wb_we pulse, pending=0, and the next grant goes to ALU.
